fright_ctrl: RTL and testbench
==============================

FRIGHT_CTRL -- requirements
Module: fright_ctrl

Interface
REQ-001 SHALL have parameter FRIGHT_FRAMES, default 360: frightened duration in frames.
REQ-002 SHALL have parameter BLINK_FRAMES, default 120: final frames of the frightened period spent in warning blink; legal range 1 to FRIGHT_FRAMES-1.
REQ-003 SHALL have parameter BLINK_PERIOD, default 15: frames per fright_blink half-period.
REQ-004 SHALL have port Clk  in  1  system clock; all state on rising edge.
REQ-005 SHALL have port Reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port frame_clk  in  1  per-frame strobe clock, asynchronous to Clk.
REQ-007 SHALL have port ate_pellet  in  1  level from pellet tracker; stays high until acknowledged.
REQ-008 SHALL have port ghost_eaten  in  1  one-Clk pulse, pacman collided with a frightened ghost.
REQ-009 SHALL have port abort  in  1  synchronous level: new_map, hard_reset or pacman death.
REQ-010 SHALL have port frightened  out  1  ghosts in frightened mode.
REQ-011 SHALL have port fright_blink  out  1  warning blink phase; 0 outside BLINK.
REQ-012 SHALL have port frames_left  out  10  remaining frightened frames.
REQ-013 SHALL have port bonus_valid  out  1  one-Clk pulse, add ghost_bonus to score.
REQ-014 SHALL have port ghost_bonus  out  11  points awarded: 200/400/800/1600.

Function
REQ-015 SHALL pass frame_clk through a 2-flop synchroniser plus rising-edge detect, giving a one-Clk frame_tick 3 Clk cycles after each frame_clk rise.
REQ-016 SHALL register ate_pellet every cycle, including under abort; pellet_edge = ate_pellet & ~registered value.
REQ-017 SHALL implement states IDLE, FRIGHT and BLINK; frightened=1 in FRIGHT and BLINK.
REQ-018 On pellet_edge in any state, SHALL load frames_left=FRIGHT_FRAMES, enter FRIGHT and reset the bonus chain to 200; frightened rises the cycle after pellet_edge.
REQ-019 On frame_tick in FRIGHT or BLINK, SHALL decrement frames_left by 1; frames_left SHALL NOT wrap below 0.
REQ-020 SHALL move FRIGHT->BLINK when the decrement yields frames_left==BLINK_FRAMES, with fright_blink=1 on entry and a blink counter cleared.
REQ-021 In BLINK, SHALL toggle fright_blink after every BLINK_PERIOD frame_ticks.
REQ-022 SHALL move to IDLE when the decrement yields 0, clearing frightened and fright_blink.
REQ-023 On ghost_eaten in FRIGHT or BLINK, SHALL pulse bonus_valid the next cycle with ghost_bonus = current chain value, then double the chain, saturating at 1600.
REQ-024 SHALL ignore ghost_eaten in IDLE: no pulse and no chain change.
REQ-025 SHALL hold ghost_bonus at its last value when bonus_valid=0.
REQ-026 Priority SHALL be abort > pellet_edge > frame_tick; a ghost_eaten coincident with pellet_edge SHALL score 200 and leave the chain at 400.
REQ-027 abort SHALL force IDLE, frames_left=0, fright_blink=0, chain=200, and suppress any bonus_valid in that cycle.

Reset
REQ-028 Reset_n low SHALL asynchronously set state IDLE, frightened=0, fright_blink=0, frames_left=0, bonus_valid=0, ghost_bonus=0, chain=200, and clear all synchroniser, edge and blink registers.
REQ-029 Reset released mid-frame SHALL NOT generate a frame_tick or pellet_edge in its first cycle.

Structure
REQ-030 Package fright_pkg SHALL hold the state enum and bonus constants BONUS_BASE=200 and BONUS_MAX=1600.
REQ-031 SHALL instantiate one sub-module, frame_tick_sync (synchroniser plus edge detect), reusable by other frame-driven blocks.

Verification (FRIGHT_FRAMES=8, BLINK_FRAMES=4, BLINK_PERIOD=2)
REQ-032 Raise ate_pellet, then 8 frame_clk pulses -> frightened high for 8 ticks; BLINK entered at frames_left=4; fright_blink sequence 1,1,0,0; IDLE at 0.
REQ-033 Four ghost_eaten pulses in FRIGHT, then a fifth -> ghost_bonus 200, 400, 800, 1600, 1600, each with a single bonus_valid pulse.
REQ-034 New ate_pellet edge while in BLINK at frames_left=2 -> FRIGHT, frames_left=8, fright_blink=0, next ghost scores 200.
REQ-035 ghost_eaten in IDLE; ate_pellet held high for 20 cycles -> no bonus_valid, exactly one restart.
REQ-036 abort asserted together with pellet_edge and ghost_eaten -> IDLE, no bonus_valid; Reset_n pulsed mid-FRIGHT -> all outputs 0 immediately.

Source files
------------

// File: rtl/fright_pkg.sv
// fright_pkg: shared state encoding and ghost bonus chain constants for fright_ctrl.
package fright_pkg;
  typedef enum logic [1:0] {IDLE, FRIGHT, BLINK} state_t;
  localparam logic [10:0] BONUS_BASE = 11'd200;
  localparam logic [10:0] BONUS_MAX  = 11'd1600;
  function automatic logic [10:0] next_bonus(input logic [10:0] b);
    return (b >= (BONUS_MAX >> 1)) ? BONUS_MAX : b << 1;
  endfunction
endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: brings a per-frame strobe clock into the Clk domain as a one-cycle tick.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic frame_tick
);
  logic [2:0] sync_q;
  logic       tick_q;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], frame_clk};
      tick_q <= sync_q[1] & ~sync_q[2];
    end
  end
  assign frame_tick = tick_q;
endmodule

// File: rtl/fright_ctrl.sv
// fright_ctrl: power-pellet frightened timer with warning blink and ghost bonus chain.
module fright_ctrl
  import fright_pkg::*;
#(
  parameter int FRIGHT_FRAMES = 360,
  parameter int BLINK_FRAMES  = 120,
  parameter int BLINK_PERIOD  = 15
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic        ate_pellet,
  input  logic        ghost_eaten,
  input  logic        abort,
  output logic        frightened,
  output logic        fright_blink,
  output logic [9:0]  frames_left,
  output logic        bonus_valid,
  output logic [10:0] ghost_bonus
);
  localparam int BW = ($clog2(BLINK_PERIOD) > 0) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [9:0]    FF_L = 10'(FRIGHT_FRAMES);
  localparam logic [9:0]    BF_L = 10'(BLINK_FRAMES);
  localparam logic [BW-1:0] BP_L = BW'(BLINK_PERIOD - 1);
  logic          frame_tick, pellet_q, armed_q, blink_q, frt_q, valid_q;
  state_t        state_q;
  logic [9:0]    frames_q, nf;
  logic [BW-1:0] bcnt_q;
  logic [10:0]   chain_q, bonus_q, eff;
  logic          pellet_edge, active;
  frame_tick_sync u_sync (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );
  // armed_q masks a pellet level already high when reset releases
  assign pellet_edge = ate_pellet & ~pellet_q & armed_q;
  assign active      = state_q != IDLE;
  assign eff         = pellet_edge ? BONUS_BASE : chain_q;
  assign nf          = (frames_q == 10'd0) ? 10'd0 : frames_q - 10'd1;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pellet_q <= 1'b0;
      armed_q  <= 1'b0;
      state_q  <= IDLE;
      frames_q <= '0;
      bcnt_q   <= '0;
      blink_q  <= 1'b0;
      frt_q    <= 1'b0;
      chain_q  <= BONUS_BASE;
      valid_q  <= 1'b0;
      bonus_q  <= '0;
    end else begin
      pellet_q <= ate_pellet;
      armed_q  <= 1'b1;
      valid_q  <= 1'b0;
      if (abort) begin
        state_q  <= IDLE;
        frames_q <= '0;
        bcnt_q   <= '0;
        blink_q  <= 1'b0;
        frt_q    <= 1'b0;
        chain_q  <= BONUS_BASE;
      end else begin
        chain_q <= eff;
        if (ghost_eaten && active) begin
          valid_q <= 1'b1;
          bonus_q <= eff;
          chain_q <= next_bonus(eff);
        end
        if (pellet_edge) begin
          state_q  <= FRIGHT;
          frames_q <= FF_L;
          bcnt_q   <= '0;
          blink_q  <= 1'b0;
          frt_q    <= 1'b1;
        end else if (frame_tick && active) begin
          frames_q <= nf;
          if (nf == 10'd0) begin
            state_q <= IDLE;
            blink_q <= 1'b0;
            frt_q   <= 1'b0;
          end else if (state_q == FRIGHT && nf == BF_L) begin
            state_q <= BLINK;
            blink_q <= 1'b1;
            bcnt_q  <= '0;
          end else if (state_q == BLINK) begin
            bcnt_q <= (bcnt_q == BP_L) ? '0 : bcnt_q + BW'(1);
            if (bcnt_q == BP_L) blink_q <= ~blink_q;
          end
        end
      end
    end
  end
  assign frightened   = frt_q;
  assign fright_blink = blink_q;
  assign frames_left  = frames_q;
  assign bonus_valid  = valid_q;
  assign ghost_bonus  = bonus_q;
endmodule

// File: tb/tb_fright_ctrl.sv
// tb_fright_ctrl: directed frightened-timer vectors with a queued scoreboard for bonus pulses.
module tb_fright_ctrl;
  logic        Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
  logic        ate_pellet = 1'b0, ghost_eaten = 1'b0, abort = 1'b0;
  logic        frightened, fright_blink, bonus_valid;
  logic [9:0]  frames_left;
  logic [10:0] ghost_bonus;
  int n_cmp = 0, n_err = 0;
  logic [10:0] exp_q[$];

  fright_ctrl #(.FRIGHT_FRAMES(8), .BLINK_FRAMES(4), .BLINK_PERIOD(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .ate_pellet(ate_pellet),
    .ghost_eaten(ghost_eaten), .abort(abort), .frightened(frightened),
    .fright_blink(fright_blink), .frames_left(frames_left),
    .bonus_valid(bonus_valid), .ghost_bonus(ghost_bonus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    step();
    frame_clk = 1'b1;
    step(5);
    frame_clk = 1'b0;
    step(3);
  endtask

  task automatic ghost(input bit expect_pulse, input logic [10:0] val);
    if (expect_pulse) exp_q.push_back(val);
    ghost_eaten = 1'b1;
    step();
    ghost_eaten = 1'b0;
    step(2);
  endtask

  task automatic repellet();
    ate_pellet = 1'b0;
    step();
    ate_pellet = 1'b1;
    step();
  endtask

  task automatic chk_all(input string tag, input int fr, input int bl, input int fl);
    @(negedge Clk);
    chk({tag, ".frightened"}, int'(frightened), fr);
    chk({tag, ".blink"}, int'(fright_blink), bl);
    chk({tag, ".frames_left"}, int'(frames_left), fl);
  endtask

  always @(negedge Clk) begin
    if (bonus_valid) begin
      if (exp_q.size() == 0) chk("bonus_unexpected", 1, 0);
      else chk("ghost_bonus", int'(ghost_bonus), int'(exp_q.pop_front()));
    end
  end

  initial begin
    int bl_tab[8] = '{0, 0, 0, 1, 1, 0, 0, 0};
    #12;
    chk_all("reset", 0, 0, 0);
    chk("reset.bonus_valid", int'(bonus_valid), 0);
    chk("reset.ghost_bonus", int'(ghost_bonus), 0);
    Reset_n = 1'b1;
    step(2);
    ate_pellet = 1'b1;
    step();
    chk_all("pellet", 1, 0, 8);
    for (int k = 1; k <= 8; k++) begin
      frame();
      chk_all($sformatf("frame%0d", k), (k < 8) ? 1 : 0, bl_tab[k-1], 8 - k);
    end
    repellet();
    chk_all("restart", 1, 0, 8);
    ghost(1, 11'd200);
    ghost(1, 11'd400);
    ghost(1, 11'd800);
    ghost(1, 11'd1600);
    ghost(1, 11'd1600);
    @(negedge Clk);
    chk("bonus_hold", int'(ghost_bonus), 1600);
    for (int k = 0; k < 6; k++) frame();
    chk_all("blink_at2", 1, 0, 2);
    repellet();
    chk_all("blink_restart", 1, 0, 8);
    ghost(1, 11'd200);
    for (int k = 0; k < 8; k++) frame();
    chk_all("idle_again", 0, 0, 0);
    ghost(0, 11'd0);
    ate_pellet = 1'b0;
    step();
    ate_pellet = 1'b1;
    step(2);
    chk_all("held_start", 1, 0, 8);
    frame();
    step(10);
    chk_all("held_once", 1, 0, 7);
    ate_pellet = 1'b0;
    step();
    ate_pellet = 1'b1;
    exp_q.push_back(11'd200);
    ghost(0, 11'd0);
    chk_all("coincide", 1, 0, 8);
    ghost(1, 11'd400);
    ate_pellet = 1'b0;
    step();
    ate_pellet = 1'b1;
    ghost_eaten = 1'b1;
    abort = 1'b1;
    step();
    ghost_eaten = 1'b0;
    abort = 1'b0;
    chk_all("abort", 0, 0, 0);
    step(3);
    chk_all("post_abort", 0, 0, 0);
    repellet();
    frame();
    chk_all("pre_reset", 1, 0, 7);
    step();
    Reset_n = 1'b0;
    #1;
    chk("rst.frightened", int'(frightened), 0);
    chk("rst.frames_left", int'(frames_left), 0);
    chk("rst.blink", int'(fright_blink), 0);
    chk("rst.bonus_valid", int'(bonus_valid), 0);
    chk("rst.ghost_bonus", int'(ghost_bonus), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step(3);
    chk_all("rst_release", 0, 0, 0);
    ghost(0, 11'd0);
    step(3);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
